// File: rtl/video_mono_pkg.sv
// rtl/video_mono_pkg.sv - mode codes, luma weights and ordered-dither thresholds
package video_mono_pkg;

  typedef enum logic [2:0] {
    MODE_COLOUR  = 3'd0,
    MODE_GREEN   = 3'd1,
    MODE_AMBER   = 3'd2,
    MODE_WHITE   = 3'd3,
    MODE_CYAN    = 3'd4,
    MODE_INVGREY = 3'd5
  } mode_e;

  localparam int LUMA_WR    = 5;
  localparam int LUMA_WG    = 9;
  localparam int LUMA_WB    = 2;
  localparam int LUMA_SHIFT = 4;

  // 2x2 Bayer thresholds packed by index {ln_par, px_par}: 00->0, 01->2, 10->3, 11->1
  localparam logic [7:0] BAYER = 8'b01_11_10_00;

  function automatic logic [1:0] bayer_thr(input logic ln_par, input logic px_par);
    case ({ln_par, px_par})
      2'b00:   bayer_thr = BAYER[1:0];
      2'b01:   bayer_thr = BAYER[3:2];
      2'b10:   bayer_thr = BAYER[5:4];
      default: bayer_thr = BAYER[7:6];
    endcase
  endfunction

endpackage

// File: rtl/mono_luma.sv
// rtl/mono_luma.sv - combinational luma (5R+9G+2B)>>4, optional 2x2 dither (VIDEO_MONO_DITHER_EN)
module mono_luma
  import video_mono_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic [CW-1:0] r,
  input  logic [CW-1:0] g,
  input  logic [CW-1:0] b,
  input  logic          px_par,
  input  logic          ln_par,
  output logic [CW-1:0] y
);

  localparam int SW = CW + LUMA_SHIFT;

  logic [SW-1:0] s;
  logic [CW-1:0] y_trunc;

  assign s = SW'(LUMA_WR) * SW'(r) + SW'(LUMA_WG) * SW'(g) + SW'(LUMA_WB) * SW'(b);
  assign y_trunc = s[SW-1:LUMA_SHIFT];

`ifdef VIDEO_MONO_DITHER_EN
  logic [1:0] frac;
  logic [1:0] thr;
  logic       unused_bits;

  assign frac = s[LUMA_SHIFT-1:LUMA_SHIFT-2];
  assign thr  = bayer_thr(ln_par, px_par);
  // round up only when it cannot wrap past full scale
  assign y = ((frac > thr) && (y_trunc != {CW{1'b1}})) ? y_trunc + CW'(1) : y_trunc;
  assign unused_bits = ^s[LUMA_SHIFT-3:0];
`else
  logic unused_bits;

  assign y = y_trunc;
  assign unused_bits = ^{s[LUMA_SHIFT-1:0], px_par, ln_par};
`endif

endmodule

// File: rtl/video_mono_filter.sv
// rtl/video_mono_filter.sv - two-stage RGB mono/palette post-processor, mode latched at vsync
// Optional ordered dither is built when VIDEO_MONO_DITHER_EN is defined.
module video_mono_filter
  import video_mono_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic [2:0]    mode_req,
  input  logic [CW-1:0] ri,
  input  logic [CW-1:0] gi,
  input  logic [CW-1:0] bi,
  input  logic          hsync_n_i,
  input  logic          vsync_n_i,
  input  logic          csync_n_i,
  output logic [CW-1:0] ro,
  output logic [CW-1:0] go,
  output logic [CW-1:0] bo,
  output logic          hsync_n_o,
  output logic          vsync_n_o,
  output logic          csync_n_o,
  output logic [2:0]    active_mode
);

  localparam int AW = CW + 3;

  logic [CW-1:0] r1, g1, b1;
  logic          hs1, vs1, cs1;
  logic          vs_fall;
  logic          px_par, ln_par;
  logic [CW-1:0] y;
  logic [AW-1:0] y5;
  logic [CW-1:0] amber_g;
  logic [CW-1:0] mr, mg, mb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1  <= '0;
      g1  <= '0;
      b1  <= '0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      cs1 <= 1'b1;
    end else begin
      r1  <= ri;
      g1  <= gi;
      b1  <= bi;
      hs1 <= hsync_n_i;
      vs1 <= vsync_n_i;
      cs1 <= csync_n_i;
    end
  end

  // Latching on the edge that loads the low vsync into stage 1 lets that sample leave with the new mode
  assign vs_fall = vs1 & ~vsync_n_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_mode <= 3'd0;
    end else if (vs_fall) begin
      active_mode <= mode_req;
    end
  end

`ifdef VIDEO_MONO_DITHER_EN
  logic hs_fall;

  assign hs_fall = hs1 & ~hsync_n_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_par <= 1'b0;
      ln_par <= 1'b0;
    end else if (vs_fall) begin
      px_par <= 1'b0;
      ln_par <= 1'b0;
    end else begin
      if (pix_en) begin
        px_par <= ~px_par;
      end
      if (hs_fall) begin
        ln_par <= ~ln_par;
      end
    end
  end
`else
  logic unused_ctl;

  assign px_par     = 1'b0;
  assign ln_par     = 1'b0;
  assign unused_ctl = pix_en;
`endif

  mono_luma #(
    .CW(CW)
  ) u_luma (
    .r      (r1),
    .g      (g1),
    .b      (b1),
    .px_par (px_par),
    .ln_par (ln_par),
    .y      (y)
  );

  assign y5      = AW'(y) * AW'(5);
  assign amber_g = y5[AW-1:3];

  always_comb begin
    mr = r1;
    mg = g1;
    mb = b1;
    case (mode_e'(active_mode))
      MODE_GREEN: begin
        mr = '0;
        mg = y;
        mb = '0;
      end
      MODE_AMBER: begin
        mr = y;
        mg = amber_g;
        mb = '0;
      end
      MODE_WHITE: begin
        mr = y;
        mg = y;
        mb = y;
      end
      MODE_CYAN: begin
        mr = '0;
        mg = y;
        mb = y;
      end
      MODE_INVGREY: begin
        mr = ~y;
        mg = ~y;
        mb = ~y;
      end
      default: begin
        mr = r1;
        mg = g1;
        mb = b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ro        <= '0;
      go        <= '0;
      bo        <= '0;
      hsync_n_o <= 1'b1;
      vsync_n_o <= 1'b1;
      csync_n_o <= 1'b1;
    end else begin
      ro        <= mr;
      go        <= mg;
      bo        <= mb;
      hsync_n_o <= hs1;
      vsync_n_o <= vs1;
      csync_n_o <= cs1;
    end
  end

endmodule
